pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the core front end.
- Consumes `branchPC` and the take-branch select from the branch-target stage. Holds the architectural PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Presents fetched instructions, with their PC and PC+4, to decode.
- Handles redirects that arrive while a fetch is in flight, and back-pressure from decode.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- pcSrc  input  1  redirect request this cycle (branch/jump taken).
- branchPC  input  ADDR_WIDTH  redirect target; sampled when pcSrc=1.
- stall  input  1  decode cannot accept an instruction this cycle.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  ADDR_WIDTH  fetch address (equals pc).
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  response data valid (1-cycle pulse).
- imem_rsp_data  input  DATA_WIDTH  fetched instruction.
- instr_valid  output  1  instr/instr_pc valid for decode.
- instr  output  DATA_WIDTH  held instruction.
- instr_pc  output  ADDR_WIDTH  PC of held instruction.
- pcPlus4  output  ADDR_WIDTH  instr_pc + 4.
- misaligned  output  1  one-cycle pulse: redirect target not word-aligned.

Behaviour:

Reset state (rst=0, asynchronous):
- State = REQ, pc = RESET_PC, kill = 0.
- imem_req_valid = 0 while rst=0, then 1 from the first cycle after release.
- instr_valid = 0; instr, instr_pc, pcPlus4 = 0; misaligned = 0.

FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req_valid = 1, imem_req_addr = pc.
  - req_valid&&req_ready → WAIT.
  - Address is stable while valid && !ready, except on redirect.
- WAIT:
  - imem_req_valid = 0. Awaiting imem_rsp_valid.
  - On response with kill = 0: capture instr = rsp_data, instr_pc = pc, pcPlus4 = pc+4, instr_valid = 1 → HOLD.
  - On response with kill = 1: discard the data, clear kill → REQ (pc already holds the redirect target).
- HOLD:
  - instr_valid = 1; outputs stable while stall = 1.
  - On the cycle with stall = 0 the instruction is consumed: next cycle instr_valid = 0, pc = pc+4 → REQ.

Redirect (pcSrc = 1 and branchPC[1:0] == 0), loads pc = branchPC at the next edge:
- REQ, request not accepted this cycle: request is replaced; next cycle imem_req_addr = branchPC.
- REQ, request accepted the same cycle: → WAIT with kill = 1.
- WAIT: kill = 1. If rsp_valid arrives the same cycle, it is discarded and the state → REQ directly, kill stays 0.
- HOLD: instr_valid drops next cycle regardless of stall → REQ.

Other redirect rules:
- A redirect takes priority over consume and over PC+4 sequencing.
- Misaligned target (branchPC[1:0] ≠ 0): redirect ignored, misaligned = 1 for one cycle, state and pc unchanged.
- A second redirect while kill = 1 updates pc only; kill remains 1, so exactly one response is dropped.

Ordering and arithmetic:
- A response is never accepted outside WAIT; rsp_valid in REQ/HOLD is ignored.
- PC arithmetic is modulo 2^ADDR_WIDTH: pc = 32'hFFFF_FFFC increments to 0.
- Reset asserted mid-operation returns to the reset state immediately; any in-flight response is ignored after release, because the state is REQ.
- Throughput: with ready=1, response latency 1 and stall=0, one instruction every 3 cycles (REQ, WAIT, HOLD).

Test Plan:
1. Reset release, memory ready=1, 1-cycle latency, rsp_data = 32'h00000013 → first request addr 0x0; instr_valid with instr_pc = 0x0, pcPlus4 = 0x4; next request addr 0x4.
2. stall held high 5 cycles in HOLD with instr = 32'hDEADBEEF, pc = 0x8 → instr, instr_pc stable for all 5 cycles, no new request; stall drop → next request addr 0xC.
3. pcSrc = 1, branchPC = 0x100 during WAIT at pc = 0x10; response 32'hAAAA arrives 2 cycles later → no instr_valid for 0xAAAA; next request addr 0x100.
4. pcSrc = 1, branchPC = 0x200 while in REQ with imem_req_ready = 0 at addr 0x20 → next cycle imem_req_addr = 0x200; response tagged to instr_pc = 0x200.
5. pcSrc = 1, branchPC = 0x102 → misaligned pulses one cycle, pc and sequence unaffected.
6. rst asserted during WAIT, response arrives after release → response ignored, fetch restarts at RESET_PC; pc = 32'hFFFF_FFFC sequential fetch → next addr 0x0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Issues one imem request at a time, holds the result for decode, and drops stale responses after redirects.
module pc_fetch_unit #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcSrc,
  input  logic [ADDR_WIDTH-1:0] branchPC,
  input  logic                  stall,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] pcPlus4,
  output logic                  misaligned
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  kill;
  logic                  live;
  logic                  aligned;
  logic                  redirect;

  assign aligned        = (branchPC[1:0] == 2'b00);
  assign redirect       = pcSrc && aligned;
  // live keeps the request low during reset and for the first edge after release
  assign imem_req_valid = live && (state == S_REQ);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      live        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      pcPlus4     <= '0;
      misaligned  <= 1'b0;
    end else begin
      live       <= 1'b1;
      misaligned <= pcSrc && !aligned;
      case (state)
        S_REQ: begin
          if (redirect) pc <= branchPC;
          if (imem_req_valid && imem_req_ready) begin
            state <= S_WAIT;
            kill  <= redirect;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (kill || redirect) begin
              state <= S_REQ;
              kill  <= 1'b0;
              if (redirect) pc <= branchPC;
            end else begin
              instr       <= imem_rsp_data;
              instr_pc    <= pc;
              pcPlus4     <= pc + ADDR_WIDTH'(4);
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end else if (redirect) begin
            pc   <= branchPC;
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc          <= branchPC;
            instr_valid <= 1'b0;
            state       <= S_REQ;
          end else if (!stall) begin
            pc          <= pc + ADDR_WIDTH'(4);
            instr_valid <= 1'b0;
            state       <= S_REQ;
          end
        end
        default: begin
          state       <= S_REQ;
          kill        <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a transaction-level model predicts requests and delivered
// instructions; a separate monitor pops the expected instruction queue when decode sees a new one.
`timescale 1ns/1ps
module tb_pc_fetch_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] RST_PC = '0;
  localparam int STEPS = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          pcSrc;
  logic [AW-1:0] branchPC;
  logic          stall;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] pcPlus4;
  logic          misaligned;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pcSrc(pcSrc), .branchPC(branchPC), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .pcPlus4(pcPlus4), .misaligned(misaligned)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   delivered = 0;

  // Model: architectural pc, one outstanding fetch (possibly doomed), one held instruction.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_req_addr;
  bit            m_live, m_pending, m_holding, m_drop, m_mis;
  int            wait_cnt;
  bit            stale;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RST_PC;
    m_live    = 0;
    m_pending = 0;
    m_holding = 0;
    m_drop    = 0;
    m_mis     = 0;
    wait_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_valid",   64'(imem_req_valid), 64'(0));
    chk("rst_instr_valid", 64'(instr_valid),    64'(0));
    chk("rst_instr",       64'(instr),          64'(0));
    chk("rst_instr_pc",    64'(instr_pc),       64'(0));
    chk("rst_pcplus4",     64'(pcPlus4),        64'(0));
    chk("rst_misaligned",  64'(misaligned),     64'(0));
  endtask

  // Monitor: a rising instr_valid presents a new instruction; while held it must not change.
  exp_t cur;
  bit   prev_v = 0;
  always @(posedge clk) begin
    #1;
    if (instr_valid === 1'b1 && !prev_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr actual instr_pc=%0h required none", instr_pc);
      end else begin
        cur = exp_q.pop_front();
        delivered++;
        chk("instr",    64'(instr),    64'(cur.data));
        chk("instr_pc", 64'(instr_pc), 64'(cur.pc));
        chk("pcplus4",  64'(pcPlus4),  64'(AW'(cur.pc + AW'(4))));
      end
    end else if (instr_valid === 1'b1) begin
      chk("hold_instr",    64'(instr),    64'(cur.data));
      chk("hold_instr_pc", 64'(instr_pc), 64'(cur.pc));
    end
    prev_v = (instr_valid === 1'b1);
  end

  initial begin
    int  mode;
    int  resets_done;
    int  lat;
    bit  redir, accept;
    rst = 1'b0;
    pcSrc = 1'b0;
    branchPC = '0;
    stall = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    stale = 0;
    resets_done = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;

    for (int step = 0; step < STEPS; step++) begin
      mode = (step < 60) ? 0 : (step < STEPS - 40) ? 1 : 2;

      // Mid-run reset while a fetch is outstanding; its response is delivered after release.
      if (mode == 1 && resets_done < 2 && step >= 1200 * (resets_done + 1)
          && m_pending && wait_cnt >= 2) begin
        resets_done++;
        rst = 1'b0;
        pcSrc = 1'b0;
        stall = 1'b0;
        imem_rsp_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        stale = 1;
      end

      chk("req_valid", 64'(imem_req_valid), 64'(m_live && !m_pending && !m_holding));
      if (m_live && !m_pending && !m_holding)
        chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
      chk("instr_valid", 64'(instr_valid), 64'(m_holding));
      chk("misaligned",  64'(misaligned),  64'(m_mis));

      imem_rsp_valid = 1'b0;
      imem_rsp_data  = (mode == 0) ? DW'(32'h0000_0013) : DW'($urandom());
      if (stale) begin
        imem_rsp_valid = 1'b1;
        stale = 0;
      end else if (wait_cnt != 0) begin
        wait_cnt--;
        if (wait_cnt == 0) imem_rsp_valid = 1'b1;
      end else if (mode == 1 && $urandom_range(0, 9) == 0) begin
        imem_rsp_valid = 1'b1;
      end
      imem_req_ready = (mode != 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
      stall = (mode == 1) ? ($urandom_range(0, 9) < 4) : 1'b0;
      pcSrc = (mode == 1) ? ($urandom_range(0, 99) < 15) : 1'b0;
      case ($urandom_range(0, 7))
        0: begin
          branchPC = AW'($urandom());
          branchPC[1:0] = 2'($urandom_range(1, 3));
        end
        1: branchPC = AW'(32'hFFFF_FFFC);
        2: branchPC = AW'(32'hFFFF_FFF4);
        default: branchPC = AW'($urandom_range(0, 255) * 4);
      endcase

      redir  = pcSrc && (branchPC[1:0] == 2'b00);
      m_mis  = pcSrc && (branchPC[1:0] != 2'b00);
      accept = m_live && !m_pending && !m_holding && imem_req_ready;
      lat    = (mode == 1) ? $urandom_range(1, 3) : 1;

      if (m_holding) begin
        if (redir) begin
          m_holding = 0;
          m_pc = branchPC;
        end else if (!stall) begin
          m_holding = 0;
          m_pc = m_pc + AW'(4);
        end
      end else if (m_pending) begin
        if (imem_rsp_valid) begin
          m_pending = 0;
          if (redir || m_drop) begin
            m_drop = 0;
            if (redir) m_pc = branchPC;
          end else begin
            exp_q.push_back('{data: imem_rsp_data, pc: m_req_addr});
            m_holding = 1;
          end
        end else if (redir) begin
          m_drop = 1;
          m_pc = branchPC;
        end
      end else begin
        if (accept) begin
          m_pending  = 1;
          m_req_addr = m_pc;
          m_drop     = redir;
          wait_cnt   = lat;
        end
        if (redir) m_pc = branchPC;
      end
      m_live = 1;

      @(negedge clk);
    end

    @(posedge clk);
    #2;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("delivered_some", 64'(delivered > 100), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
